qerv_dbus_ctrl: RTL and testbench
=================================

# qerv_dbus_ctrl

Data-bus master stage sitting directly downstream of the bit-serial buffer register (qerv_bufreg2): it takes the parallel store word and the byte offset held there, runs one Wishbone-style data-bus cycle per load/store, and returns the raw read word plus a one-cycle load strobe that reloads the buffer register. It also generates byte selects, detects misalignment, and enforces a bus timeout so a dead slave cannot hang the core.

## Interface
- TIMEOUT, default 255: max cycles CYC stays high without ACK/ERR before abort; 0 disables the timeout.
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  start request from core state logic, sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- i_lsb  in  2  byte offset within word
- i_adr  in  32  byte address from address buffer
- i_wdat  in  32  store word, already lane-aligned by buffer register
- o_rdat  out  32  registered raw read word (to buffer register i_dat)
- o_load  out  1  one-cycle strobe, read word valid (to buffer register i_load)
- o_done  out  1  one-cycle completion strobe (success, error, or misalign)
- o_err  out  1  one-cycle strobe with o_done on bus error or timeout
- o_misalign  out  1  one-cycle strobe with o_done on misaligned request
- o_dbus_adr  out  32  word address {i_adr[31:2],2'b00}
- o_dbus_dat  out  32  write data
- o_dbus_sel  out  4  byte enables
- o_dbus_we  out  1  write enable
- o_dbus_cyc  out  1  cycle/strobe
- i_dbus_rdt  in  32  read data
- i_dbus_ack  in  1  slave acknowledge
- i_dbus_err  in  1  slave error

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: on i_req, decode sel/misalign. Misaligned (half with lsb[0]=1, word with lsb≠0): no bus cycle, pulse o_done+o_misalign next cycle, stay IDLE. Otherwise latch adr/dat/sel/we into output registers, set cyc, clear timeout counter, go BUSY.
- sel: byte → 1<<lsb; half → lsb[1] ? 4'b1100 : 4'b0011; word → 4'b1111.
- BUSY: outputs held stable. On i_dbus_err: drop cyc, go RESP with error flag. Else on i_dbus_ack: drop cyc, capture i_dbus_rdt into o_rdat if load, go RESP. Else if TIMEOUT≠0 and counter == TIMEOUT−1: drop cyc, go RESP with error flag. Else counter++.
- ACK and ERR same cycle: ERR wins, o_rdat not updated, no o_load.
- RESP (1 cycle): o_done=1; o_load=1 iff load and no error; o_err=error flag; return to IDLE.
- i_req outside IDLE ignored; a new request is accepted the cycle after RESP.
- o_rdat unmodified raw word; byte/half extraction and sign handling stay in the buffer register via i_lsb.

## Timing
- Reset (async): state IDLE, all outputs 0, counter 0, o_rdat 0.
- i_req at cycle N → o_dbus_cyc high from N+1.
- ACK at cycle M (earliest M = N+1, zero-wait slave) → cyc low at M+1, o_done/o_load high at M+1 for exactly one cycle.
- Misalign: i_req at N → o_done+o_misalign at N+1 only.
- Timeout: cyc high exactly TIMEOUT cycles, o_done+o_err the following cycle.
- Reset mid-cycle: cyc drops asynchronously; no o_done emitted.
- Counter width $clog2(TIMEOUT+1); never wraps.

## Structure
- Shared package qerv_pkg: size encodings (SIZE_B/H/W) and state encoding constants.
- Sub-module qerv_dbus_sel: combinational (size, lsb) → sel[3:0], misalign.
- FSM, timeout counter, and output registers in top module.

## Test plan
- Load word, adr 0x1000, slave ACK after 2 waits with rdt 0xDEADBEEF → cyc 3 cycles, o_dbus_sel 4'hF, o_rdat 0xDEADBEEF, o_load+o_done one cycle.
- Store byte, adr 0x2003, wdat 0xAB000000 → o_dbus_adr 0x2000, sel 4'b1000, we 1, o_done without o_load.
- Half at adr 0x3001 → no cyc, o_misalign+o_done at N+1; word at 0x3002 same.
- TIMEOUT=4, slave silent → cyc high 4 cycles, then o_err+o_done, no o_load.
- ACK and ERR together on load → o_err, o_rdat unchanged, no o_load; i_req during BUSY ignored.
- i_rst asserted while BUSY → cyc 0 immediately, no o_done, next i_req accepted normally.

Source files
------------

// File: rtl/qerv_pkg.sv
// Shared encodings for the qerv data-bus stage: access sizes and controller states.
package qerv_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dbus_state_t;

endpackage

// File: rtl/qerv_dbus_ctrl_if.sv
// Core-side request/response and Wishbone-style data-bus signals of qerv_dbus_ctrl.
interface qerv_dbus_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [1:0]  lsb;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        load;
  logic        done;
  logic        err;
  logic        misalign;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        dbus_err;

  modport master (
    input  req, we, size, lsb, adr, wdat, dbus_rdt, dbus_ack, dbus_err,
    output rdat, load, done, err, misalign,
    output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc
  );

  modport slave (
    output req, we, size, lsb, adr, wdat, dbus_rdt, dbus_ack, dbus_err,
    input  rdat, load, done, err, misalign,
    input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc
  );
endinterface

// File: rtl/qerv_dbus_sel.sv
// Byte-enable and misalignment decode from access size and byte offset.
module qerv_dbus_sel
  import qerv_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] lsb,
  output logic [3:0] sel,
  output logic       misalign
);

  always_comb begin
    sel      = 4'b1111;
    misalign = 1'b0;
    case (size)
      SIZE_B: sel = 4'b0001 << lsb;
      SIZE_H: begin
        sel      = lsb[1] ? 4'b1100 : 4'b0011;
        misalign = lsb[0];
      end
      // size 3 decodes as a word access
      default: misalign = |lsb;
    endcase
  end

endmodule

// File: rtl/qerv_dbus_ctrl.sv
// Data-bus master stage: one bus cycle per load/store with byte selects,
// misalignment rejection and a bus timeout.
module qerv_dbus_ctrl
  import qerv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  qerv_dbus_ctrl_if.master bus
);

  localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  dbus_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   rdat, rdat_n, adr, adr_n, dat, dat_n;
  logic [3:0]    sel, sel_n;
  logic          we, we_n, cyc, cyc_n;
  logic          done, done_n, load, load_n, err, err_n, mis, mis_n;
  logic [3:0]    dec_sel;
  logic          dec_mis;

  qerv_dbus_sel u_sel (
    .size     (bus.size),
    .lsb      (bus.lsb),
    .sel      (dec_sel),
    .misalign (dec_mis)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rdat  <= '0;
      adr   <= '0;
      dat   <= '0;
      sel   <= '0;
      we    <= 1'b0;
      cyc   <= 1'b0;
      done  <= 1'b0;
      load  <= 1'b0;
      err   <= 1'b0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdat  <= rdat_n;
      adr   <= adr_n;
      dat   <= dat_n;
      sel   <= sel_n;
      we    <= we_n;
      cyc   <= cyc_n;
      done  <= done_n;
      load  <= load_n;
      err   <= err_n;
      mis   <= mis_n;
    end
  end

  // Response strobes are registered on the BUSY->RESP edge, so they are high
  // exactly while the FSM sits in RESP; misalign pulses the same way from IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdat_n  = rdat;
    adr_n   = adr;
    dat_n   = dat;
    sel_n   = sel;
    we_n    = we;
    cyc_n   = cyc;
    done_n  = 1'b0;
    load_n  = 1'b0;
    err_n   = 1'b0;
    mis_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (dec_mis) begin
            done_n = 1'b1;
            mis_n  = 1'b1;
          end else begin
            adr_n   = {bus.adr[31:2], 2'b00};
            dat_n   = bus.wdat;
            sel_n   = dec_sel;
            we_n    = bus.we;
            cyc_n   = 1'b1;
            cnt_n   = '0;
            state_n = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (bus.dbus_err) begin
          cyc_n   = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else if (bus.dbus_ack) begin
          cyc_n   = 1'b0;
          done_n  = 1'b1;
          if (!we) begin
            rdat_n = bus.dbus_rdt;
            load_n = 1'b1;
          end
          state_n = ST_RESP;
        end else if (TIMEOUT != 0 && cnt == CW'(LAST)) begin
          cyc_n   = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.rdat     = rdat;
  assign bus.load     = load;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.misalign = mis;
  assign bus.dbus_adr = adr;
  assign bus.dbus_dat = dat;
  assign bus.dbus_sel = sel;
  assign bus.dbus_we  = we;
  assign bus.dbus_cyc = cyc;

endmodule

// File: tb/tb_qerv_dbus_ctrl.sv
// Directed bench for qerv_dbus_ctrl: transaction table plus timeout,
// ACK+ERR and mid-cycle reset sequences.
module tb_qerv_dbus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qerv_dbus_ctrl_if bus ();

  qerv_dbus_ctrl #(.TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [1:0]  lsb;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdt;
    int          waits;
    logic        exp_mis;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr;
    logic        exp_load;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] adr,
                       input logic [31:0] wdat);
    bus.req  = 1'b1;
    bus.we   = we;
    bus.size = size;
    bus.lsb  = adr[1:0];
    bus.adr  = adr;
    bus.wdat = wdat;
    tick();
    bus.req  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc_cycles;
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v.we, v.size, v.adr, v.wdat);
    if (v.exp_mis) begin
      check({tag, ".mis_cyc"}, 32'(bus.dbus_cyc), 32'd0);
      check({tag, ".mis_done"}, 32'(bus.done), 32'd1);
      check({tag, ".mis_flag"}, 32'(bus.misalign), 32'd1);
      check({tag, ".mis_err"}, 32'(bus.err), 32'd0);
      tick();
      check({tag, ".mis_done_end"}, {30'd0, bus.done, bus.misalign}, 32'd0);
      check({tag, ".mis_nocyc"}, 32'(bus.dbus_cyc), 32'd0);
      return;
    end
    check({tag, ".adr"}, bus.dbus_adr, v.exp_adr);
    check({tag, ".sel"}, 32'(bus.dbus_sel), 32'(v.exp_sel));
    check({tag, ".we"}, 32'(bus.dbus_we), 32'(v.we));
    if (v.we) check({tag, ".dat"}, bus.dbus_dat, v.wdat);
    cyc_cycles = 0;
    for (int w = 0; w < v.waits; w++) begin
      if (bus.dbus_cyc) cyc_cycles++;
      tick();
    end
    if (bus.dbus_cyc) cyc_cycles++;
    bus.dbus_ack = 1'b1;
    bus.dbus_rdt = v.rdt;
    tick();
    bus.dbus_ack = 1'b0;
    bus.dbus_rdt = 32'h0;
    check({tag, ".cyc_len"}, 32'(cyc_cycles), 32'(v.waits + 1));
    check({tag, ".cyc_drop"}, 32'(bus.dbus_cyc), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".load"}, 32'(bus.load), 32'(v.exp_load));
    check({tag, ".err"}, 32'(bus.err), 32'd0);
    check({tag, ".rdat"}, bus.rdat, v.exp_rdat);
    tick();
    check({tag, ".strobe_end"}, {30'd0, bus.done, bus.load}, 32'd0);
  endtask

  initial begin
    int n;
    // we size lsb adr wdat rdt waits mis sel adr load rdat
    vecs[0] = '{1'b0, 2'd2, 2'd0, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 1'b0, 4'hF, 32'h1000, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'd0, 2'd3, 32'h2003, 32'hAB000000, 32'h11111111, 0, 1'b0, 4'h8, 32'h2000, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 2'd1, 2'd1, 32'h3001, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 2'd2, 2'd2, 32'h3002, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 2'd1, 2'd2, 32'h4002, 32'h0, 32'h12345678, 1, 1'b0, 4'hC, 32'h4000, 1'b1, 32'h12345678};
    vecs[5] = '{1'b0, 2'd0, 2'd1, 32'h5001, 32'h0, 32'hCAFEF00D, 0, 1'b0, 4'h2, 32'h5000, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 2'd1, 2'd0, 32'h6000, 32'h0000BEEF, 32'h22222222, 1, 1'b0, 4'h3, 32'h6000, 1'b0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 2'd3, 2'd0, 32'h7000, 32'h0, 32'h0BADF00D, 0, 1'b0, 4'hF, 32'h7000, 1'b1, 32'h0BADF00D};
    vecs[8] = '{1'b0, 2'd3, 2'd1, 32'h7001, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0BADF00D};

    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.lsb = 2'd0;
    bus.adr = '0; bus.wdat = '0;
    bus.dbus_rdt = '0; bus.dbus_ack = 1'b0; bus.dbus_err = 1'b0;

    tick();
    check("rst.cyc", 32'(bus.dbus_cyc), 32'd0);
    check("rst.strobes", {28'd0, bus.done, bus.load, bus.err, bus.misalign}, 32'd0);
    check("rst.rdat", bus.rdat, 32'd0);
    check("rst.adr", bus.dbus_adr, 32'd0);
    check("rst.sel", 32'(bus.dbus_sel), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Silent slave: cyc must stay up exactly TIMEOUT cycles, then error.
    issue(1'b0, 2'd2, 32'h8000, 32'h0);
    n = 0;
    while (bus.dbus_cyc && n < 20) begin
      n++;
      tick();
    end
    check("to.cyc_len", 32'(n), 32'd4);
    check("to.done", 32'(bus.done), 32'd1);
    check("to.err", 32'(bus.err), 32'd1);
    check("to.load", 32'(bus.load), 32'd0);
    check("to.rdat", bus.rdat, 32'h0BADF00D);
    tick();
    check("to.strobe_end", {30'd0, bus.done, bus.err}, 32'd0);

    // ACK with ERR: error wins; a request raised during BUSY is ignored.
    issue(1'b0, 2'd2, 32'h9000, 32'h0);
    bus.req = 1'b1; bus.we = 1'b1; bus.adr = 32'hA004; bus.lsb = 2'd0;
    tick();
    check("ae.busy_cyc", 32'(bus.dbus_cyc), 32'd1);
    check("ae.busy_adr", bus.dbus_adr, 32'h9000);
    check("ae.busy_we", 32'(bus.dbus_we), 32'd0);
    bus.req = 1'b0;
    bus.dbus_ack = 1'b1; bus.dbus_err = 1'b1; bus.dbus_rdt = 32'hFFFFFFFF;
    tick();
    bus.dbus_ack = 1'b0; bus.dbus_err = 1'b0; bus.dbus_rdt = '0;
    check("ae.done", 32'(bus.done), 32'd1);
    check("ae.err", 32'(bus.err), 32'd1);
    check("ae.load", 32'(bus.load), 32'd0);
    check("ae.rdat", bus.rdat, 32'h0BADF00D);
    tick();
    check("ae.no_new_cyc", 32'(bus.dbus_cyc), 32'd0);
    check("ae.strobe_end", 32'(bus.done), 32'd0);

    // Reset in the middle of a bus cycle.
    issue(1'b0, 2'd2, 32'hB000, 32'h0);
    check("rb.cyc_up", 32'(bus.dbus_cyc), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rb.cyc_async", 32'(bus.dbus_cyc), 32'd0);
    check("rb.rdat", bus.rdat, 32'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.done) n++;
      tick();
    end
    check("rb.no_done", 32'(n), 32'd0);
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
